// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
// The optional MULT_PERF_CNT_EN build uses PERF_CNT_W for its completion counter.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int PERF_CNT_W = 16;

  // Iteration counter must be able to hold N itself, not only N-1.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_if.sv
// Start/done handshake and operand/result bus of the shift-add multiplier.
// op_count exists only when MULT_PERF_CNT_EN is defined.
interface shift_add_mult_ctrl_if #(
  parameter int N = 4
);
  import mult_pkg::*;

  logic              start;
  logic [N-1:0]      a;
  logic [N-1:0]      b;
  logic              busy;
  logic              done;
  logic [2*N-1:0]    product;
`ifdef MULT_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] op_count;
`endif

  modport master (
    output start, a, b,
`ifdef MULT_PERF_CNT_EN
    input  op_count,
`endif
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
`ifdef MULT_PERF_CNT_EN
    output op_count,
`endif
    output busy, done, product
  );

endinterface

// File: rtl/shift_add_mult_ctrl_ripple_add_n.sv
// Combinational N-bit ripple-carry adder with carry-in and carry-out.
module ripple_add_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  logic [N:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[N];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned NxN shift-add multiplier: one add/shift per clock through a shared adder.
// Define MULT_PERF_CNT_EN to add the 16-bit completed-multiply counter (op_count).
module shift_add_mult_ctrl
  import mult_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_add_mult_ctrl_if.slave bus
);

  localparam int CW = cnt_w(N);

  mult_state_t      state_q;
  logic [N-1:0]     mcand_q;
  logic [2*N:0]     acc_q;
  logic [CW-1:0]    count_q;
  logic [2*N-1:0]   product_q;
  logic             busy_q;
  logic             done_q;

  logic [N-1:0]     addend;
  logic [N-1:0]     sum;
  logic             cout;
  logic [2*N:0]     acc_d;
  logic             last_iter;

  assign addend = acc_q[0] ? mcand_q : '0;

  ripple_add_n #(.N(N)) u_add (
    .a_i   (acc_q[2*N-1:N]),
    .b_i   (addend),
    .cin_i (1'b0),
    .sum_o (sum),
    .cout_o(cout)
  );

  // acc_q[2*N] is always zero between iterations; it sits in the carry slot before the shift.
  assign acc_d     = {1'b0, cout | acc_q[2*N], sum, acc_q[N-1:1]};
  assign last_iter = (count_q == CW'(N - 1));

`ifdef MULT_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] op_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q <= '0;
    end else if (state_q == DONE) begin
      op_count_q <= op_count_q + PERF_CNT_W'(1);
    end
  end

  assign bus.op_count = op_count_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mcand_q <= bus.a;
            acc_q   <= {1'b0, {N{1'b0}}, bus.b};
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          count_q <= count_q + CW'(1);
          if (last_iter) begin
            product_q <= acc_d[2*N-1:0];
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed plus randomized bench for shift_add_mult_ctrl; reference is plain a*b arithmetic.
// Build with MULT_PERF_CNT_EN defined to also exercise op_count.
module tb_shift_add_mult_ctrl;

  localparam int N = 4;

  logic clk;
  logic rst;

  int ncmp = 0;
  int nerr = 0;
  int done_seen = 0;
  int exp_dones = 0;
  int exp_ops = 0;
  logic [2*N-1:0] exp_prod = '0;

  shift_add_mult_ctrl_if #(.N(N)) bus ();

  shift_add_mult_ctrl #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at #1 after an edge with the DUT in IDLE; returns at #1 after the DONE->IDLE edge.
  task automatic run_mult(input int av, input int bv, input bit poke);
    logic [2*N-1:0] ref_p;
    ref_p = (2*N)'(av * bv);
    bus.a = N'(av);
    bus.b = N'(bv);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    chk("done_after_accept", 32'(bus.done), 32'd0);
    for (int i = 1; i <= N; i++) begin
      @(posedge clk); #1;
      if (i < N) begin
        chk("busy_run", 32'(bus.busy), 32'd1);
        chk("done_run", 32'(bus.done), 32'd0);
        chk("product_hold_run", 32'(bus.product), 32'(exp_prod));
        if (poke && i == 2) begin
          bus.start = 1'b1;
          bus.a = N'(1);
          bus.b = N'(1);
        end else if (poke && i == 3) begin
          bus.start = 1'b0;
        end
      end else begin
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("busy_done", 32'(bus.busy), 32'd1);
        chk("product", 32'(bus.product), 32'(ref_p));
      end
    end
    exp_prod = ref_p;
    exp_dones++;
    @(posedge clk); #1;
    exp_ops++;
    chk("done_clear", 32'(bus.done), 32'd0);
    chk("busy_clear", 32'(bus.busy), 32'd0);
    chk("product_hold_idle", 32'(bus.product), 32'(exp_prod));
  endtask

  initial begin
    int ra, rb;
    int d0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_product", 32'(bus.product), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_mult(13, 11, 1'b0);
    run_mult(15, 15, 1'b0);
    run_mult(0, 9, 1'b0);
    run_mult(9, 0, 1'b0);

    // start held high: second accept lands on the first IDLE edge
    d0 = done_seen;
    bus.a = N'(3);
    bus.b = N'(5);
    bus.start = 1'b1;
    @(posedge clk); #1;
    chk("hold_busy_acc1", 32'(bus.busy), 32'd1);
    for (int i = 1; i <= N; i++) begin
      @(posedge clk); #1;
    end
    chk("hold_done1", 32'(bus.done), 32'd1);
    chk("hold_prod1", 32'(bus.product), 32'd15);
    bus.a = N'(7);
    bus.b = N'(6);
    @(posedge clk); #1;
    chk("hold_idle_busy", 32'(bus.busy), 32'd0);
    chk("hold_idle_done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    chk("hold_busy_acc2", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    for (int i = 1; i <= N; i++) begin
      @(posedge clk); #1;
      if (i < N) chk("hold_prod_keep", 32'(bus.product), 32'd15);
    end
    chk("hold_done2", 32'(bus.done), 32'd1);
    chk("hold_prod2", 32'(bus.product), 32'd42);
    @(posedge clk); #1;
    chk("hold_done_count", 32'(done_seen - d0), 32'd2);
    exp_prod = (2*N)'(42);
    exp_dones += 2;
    exp_ops += 2;

    // start re-pulsed mid-RUN is ignored
    d0 = done_seen;
    run_mult(9, 9, 1'b1);
    @(posedge clk); #1;
    chk("poke_single_done", 32'(done_seen - d0), 32'd1);
    chk("poke_stays_idle", 32'(bus.busy), 32'd0);

    // asynchronous reset in cycle 2 of RUN
    bus.a = N'(5);
    bus.b = N'(5);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_product", 32'(bus.product), 32'd0);
    #1 rst = 1'b0;
    exp_prod = '0;
    exp_ops = 0;
    d0 = done_seen;
    @(posedge clk); #1;
    chk("arst_idle", 32'(bus.busy), 32'd0);
    run_mult(6, 7, 1'b0);

    for (int k = 0; k < 16; k++) begin
      ra = int'($urandom_range(0, (1 << N) - 1));
      rb = int'($urandom_range(0, (1 << N) - 1));
      run_mult(ra, rb, 1'b0);
    end
    chk("done_total_after_rst", 32'(done_seen - d0), 32'(exp_dones - (exp_dones - 17)));

`ifdef MULT_PERF_CNT_EN
    chk("op_count", 32'(bus.op_count), 32'(exp_ops));
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    @(posedge clk); #1;
    chk("op_count_preload", 32'(bus.op_count), 32'h0000FFFF);
    run_mult(2, 3, 1'b0);
    chk("op_count_wrap", 32'(bus.op_count), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    nerr++;
    $display("FAIL timeout observed=running expected=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $fatal(1, "timeout");
  end

endmodule
